// File: rtl/decoder_test_sequencer.sv
// decoder_test_sequencer: replays syndrome tests into a lattice decoder
// and scores the returned roots against an expected-root stream.
module decoder_test_sequencer #(
  parameter int CODE_DISTANCE_X = 5,
  parameter int CODE_DISTANCE_Z = 4,
  parameter int MEASUREMENT_ROUNDS =
    (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
    CODE_DISTANCE_X : CODE_DISTANCE_Z,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit STOP_ON_FAIL = 1'b1,
  localparam int PU_COUNT =
    CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int PDW = ($clog2(MEASUREMENT_ROUNDS) < 1) ?
    1 : $clog2(MEASUREMENT_ROUNDS),
  localparam int AW = 3 * PDW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            exp_data,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  output logic [PU_COUNT-1:0]    is_error_syndromes,
  output logic                   new_round_start,
  input  logic [AW*PU_COUNT-1:0] roots,
  input  logic                   result_valid,
  input  logic                   deadlock,
  output logic [31:0]            pass_count,
  output logic [31:0]            fail_count,
  output logic [15:0]            timeout_count,
  output logic [31:0]            last_test_id,
  output logic                   done,
  output logic                   halted
);

  localparam int IW = ($clog2(PU_COUNT) < 1) ?
    1 : $clog2(PU_COUNT);
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ?
    1 : $clog2(TIMEOUT_CYCLES);

  if (PDW > 8) begin : g_pdw_chk
    $error("MEASUREMENT_ROUNDS too large");
  end

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD_HDR = 4'd1;
  localparam logic [3:0] S_LOAD_SYN = 4'd2;
  localparam logic [3:0] S_START    = 4'd3;
  localparam logic [3:0] S_WAIT     = 4'd4;
  localparam logic [3:0] S_CHK_HDR  = 4'd5;
  localparam logic [3:0] S_CHK      = 4'd6;
  localparam logic [3:0] S_REPORT   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;

  logic [3:0]    state;
  logic [31:0]   test_id;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic          fail;
  logic          skip;
  logic          last_word;
  logic          root_hit;
  logic          tmo_hit;
  logic [AW-1:0] exp_root;
  logic [AW-1:0] root_arr [PU_COUNT];

  for (genvar g = 0; g < PU_COUNT; g++) begin : g_root
    assign root_arr[g] = roots[g*AW +: AW];
  end

  assign exp_root = {exp_data[16 +: PDW],
                     exp_data[8 +: PDW],
                     exp_data[PDW-1:0]};

  assign last_word = idx == IW'(PU_COUNT - 1);
  assign root_hit  = exp_root == root_arr[idx];
  // fires on the edge where the timer would reach TIMEOUT_CYCLES-1
  assign tmo_hit   = timer == TW'(TIMEOUT_CYCLES - 2);

  assign in_ready = (state == S_LOAD_HDR && enable) ||
                    state == S_LOAD_SYN;
  assign exp_ready = state == S_CHK_HDR || state == S_CHK;
  assign new_round_start = state == S_START;
  assign done = state == S_DONE || state == S_HALT;
  assign halted = state == S_HALT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      test_id            <= '0;
      idx                <= '0;
      timer              <= '0;
      fail               <= 1'b0;
      skip               <= 1'b0;
      is_error_syndromes <= '0;
      pass_count         <= '0;
      fail_count         <= '0;
      timeout_count      <= '0;
      last_test_id       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable) state <= S_LOAD_HDR;
        end
        S_LOAD_HDR: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (in_valid) begin
            if (in_data == 32'hFFFF_FFFF) begin
              state <= S_DONE;
            end else begin
              test_id            <= in_data;
              is_error_syndromes <= '0;
              idx                <= '0;
              fail               <= 1'b0;
              skip               <= 1'b0;
              state              <= S_LOAD_SYN;
            end
          end
        end
        S_LOAD_SYN: begin
          if (in_valid) begin
            is_error_syndromes[idx] <= in_data[0];
            if (last_word) state <= S_START;
            else idx <= idx + 1'b1;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (deadlock) begin
            fail  <= 1'b1;
            skip  <= 1'b1;
            state <= S_CHK_HDR;
          end else if (result_valid) begin
            state <= S_CHK_HDR;
          end else if (tmo_hit) begin
            fail  <= 1'b1;
            skip  <= 1'b1;
            state <= S_CHK_HDR;
            if (~&timeout_count)
              timeout_count <= timeout_count + 16'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHK_HDR: begin
          if (exp_valid) begin
            if (exp_data != test_id) fail <= 1'b1;
            idx   <= '0;
            state <= S_CHK;
          end
        end
        S_CHK: begin
          if (exp_valid) begin
            if (!skip && !root_hit) fail <= 1'b1;
            if (last_word) state <= S_REPORT;
            else idx <= idx + 1'b1;
          end
        end
        S_REPORT: begin
          last_test_id <= test_id;
          if (fail) begin
            if (~&fail_count) fail_count <= fail_count + 32'd1;
          end else begin
            if (~&pass_count) pass_count <= pass_count + 32'd1;
          end
          if (fail && STOP_ON_FAIL) state <= S_HALT;
          else state <= S_LOAD_HDR;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
